// File: rtl/mem_arbiter_pkg.sv
// Shared types, encodings and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SIZE_W = 2;

  // Address parked on the shared port whenever no request is being presented
  localparam logic [ADDR_W-1:0] DEF_ENTRYPOINT = 32'h1c00_0000;

  // Access size codes
  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  // Owner / grant identifiers
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Request payload presented on the shared memory port
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Parked command: entry address, everything else zero
  function automatic mem_cmd_t idle_cmd(input logic [ADDR_W-1:0] entry);
    mem_cmd_t c;
    c       = '0;
    c.size  = SIZE_BYTE;
    c.addr  = entry;
    return c;
  endfunction

  // Instruction fetches are always word reads with no strobes
  function automatic mem_cmd_t inst_cmd(input logic [ADDR_W-1:0] addr);
    mem_cmd_t c;
    c      = '0;
    c.size = SIZE_WORD;
    c.addr = addr;
    return c;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side handshake signals around the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Instruction requester
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  // Data requester
  logic              data_req;
  logic              data_wr;
  logic [SIZE_W-1:0] data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [STRB_W-1:0] data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // Shared memory port
  logic              mem_req;
  logic              mem_wr;
  logic [SIZE_W-1:0] mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata
  );

  // Environment view (requesters plus memory)
  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection between the instruction and data requesters.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic last_grant_i,
  input  logic inst_req_i,
  input  logic data_req_i,
  output logic win_data_o
);

  // Fixed mode: data always wins. Round-robin: a tie goes to whoever was not granted last.
  always_comb begin
    win_data_o = data_req_i;
    if (RR && inst_req_i && data_req_i) begin
      win_data_o = (last_grant_i == OWN_INST);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto one shared memory port, one transaction in flight.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit                RR         = 1'b0,
  parameter logic [ADDR_W-1:0] ENTRYPOINT = DEF_ENTRYPOINT
) (
  input logic          clk,
  input logic          resetn,
  mem_arbiter_if.slave bus
);

  arb_state_e state_q;
  logic       owner_q;
  logic       last_grant_q;
  logic       win_data;
  logic       in_req;
  logic       in_resp;
  logic       accept;
  logic       respond;
  mem_cmd_t   cmd;

  arb_pick #(.RR(RR)) u_pick (
    .last_grant_i (last_grant_q),
    .inst_req_i   (bus.inst_req),
    .data_req_i   (bus.data_req),
    .win_data_o   (win_data)
  );

  // Arbitration FSM: pick in IDLE, present in REQ until accepted, wait for response in RESP
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      last_grant_q <= OWN_DATA;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.inst_req || bus.data_req) begin
            owner_q <= win_data;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_addr_ok) begin
            last_grant_q <= owner_q;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (bus.mem_data_ok) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_req  = (state_q == REQ);
  assign in_resp = (state_q == RESP);
  assign accept  = in_req  && bus.mem_addr_ok;
  assign respond = in_resp && bus.mem_data_ok;

  // Shared-port command: the owner's fields while requesting, parked otherwise
  always_comb begin
    cmd = idle_cmd(ENTRYPOINT);
    if (in_req) begin
      if (owner_q == OWN_DATA) begin
        cmd.wr    = bus.data_wr;
        cmd.size  = bus.data_size;
        cmd.addr  = bus.data_addr;
        cmd.wstrb = bus.data_wstrb;
        cmd.wdata = bus.data_wdata;
      end else begin
        cmd = inst_cmd(bus.inst_addr);
      end
    end
  end

  assign bus.mem_req   = in_req;
  assign bus.mem_wr    = cmd.wr;
  assign bus.mem_size  = cmd.size;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wstrb = cmd.wstrb;
  assign bus.mem_wdata = cmd.wdata;

  // Handshake pulses pass straight through to the current owner only
  assign bus.inst_addr_ok = accept  && (owner_q == OWN_INST);
  assign bus.data_addr_ok = accept  && (owner_q == OWN_DATA);
  assign bus.inst_data_ok = respond && (owner_q == OWN_INST);
  assign bus.data_data_ok = respond && (owner_q == OWN_DATA);
  assign bus.inst_rdata   = (respond && (owner_q == OWN_INST)) ? bus.mem_rdata : '0;
  assign bus.data_rdata   = (respond && (owner_q == OWN_DATA)) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one fixed-priority and one round-robin instance
// share the same stimulus and are checked every cycle against a transaction model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct packed {
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
  } stim_t;

  typedef struct packed {
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
  } obs_t;

  logic  clk    = 1'b0;
  logic  resetn = 1'b0;
  stim_t s;
  obs_t  ob   [2];
  obs_t  snap [2];

  int err = 0;
  int chk = 0;
  int cyc = 0;

  // Model: a transaction is either absent, awaiting acceptance, or awaiting its response
  bit m_busy [2];
  bit m_acc  [2];
  bit m_own  [2];
  bit m_last [2];

  // Observation logs (grant owner per accepted request, and cycle stamps for instance 0)
  bit gq0 [$];
  bit gq1 [$];
  int gcyc0 [$];
  int dcyc0 [$];

  always #5 clk = ~clk;

  mem_arbiter_if bus0 ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.RR(1'b0)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  mem_arbiter #(.RR(1'b1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  assign bus0.inst_req    = s.inst_req;
  assign bus0.inst_addr   = s.inst_addr;
  assign bus0.data_req    = s.data_req;
  assign bus0.data_wr     = s.data_wr;
  assign bus0.data_size   = s.data_size;
  assign bus0.data_addr   = s.data_addr;
  assign bus0.data_wstrb  = s.data_wstrb;
  assign bus0.data_wdata  = s.data_wdata;
  assign bus0.mem_addr_ok = s.mem_addr_ok;
  assign bus0.mem_data_ok = s.mem_data_ok;
  assign bus0.mem_rdata   = s.mem_rdata;

  assign bus1.inst_req    = s.inst_req;
  assign bus1.inst_addr   = s.inst_addr;
  assign bus1.data_req    = s.data_req;
  assign bus1.data_wr     = s.data_wr;
  assign bus1.data_size   = s.data_size;
  assign bus1.data_addr   = s.data_addr;
  assign bus1.data_wstrb  = s.data_wstrb;
  assign bus1.data_wdata  = s.data_wdata;
  assign bus1.mem_addr_ok = s.mem_addr_ok;
  assign bus1.mem_data_ok = s.mem_data_ok;
  assign bus1.mem_rdata   = s.mem_rdata;

  // Gather both instances' outputs into comparable records
  always_comb begin
    ob[0] = {bus0.inst_addr_ok, bus0.inst_data_ok, bus0.inst_rdata,
             bus0.data_addr_ok, bus0.data_data_ok, bus0.data_rdata,
             bus0.mem_req, bus0.mem_wr, bus0.mem_size, bus0.mem_addr,
             bus0.mem_wstrb, bus0.mem_wdata};
    ob[1] = {bus1.inst_addr_ok, bus1.inst_data_ok, bus1.inst_rdata,
             bus1.data_addr_ok, bus1.data_data_ok, bus1.data_rdata,
             bus1.mem_req, bus1.mem_wr, bus1.mem_size, bus1.mem_addr,
             bus1.mem_wstrb, bus1.mem_wdata};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_acc[k]  = 1'b0;
      m_own[k]  = 1'b0;
      m_last[k] = 1'b1;
    end
  endtask

  // Who gets the port: instance 0 favours data; instance 1 alternates on ties
  function automatic bit pick(input int k);
    if (k == 1 && s.inst_req && s.data_req) return !m_last[k];
    return s.data_req;
  endfunction

  // Expected outputs from the transaction phase and the current inputs
  function automatic obs_t model_out(input int k);
    obs_t e;
    bit   asking, waiting, acc, rsp;
    e        = '0;
    e.mem_addr = 32'h1c00_0000;
    asking   = m_busy[k] && !m_acc[k];
    waiting  = m_busy[k] &&  m_acc[k];
    if (asking) begin
      e.mem_req = 1'b1;
      if (m_own[k]) begin
        e.mem_wr    = s.data_wr;
        e.mem_size  = s.data_size;
        e.mem_addr  = s.data_addr;
        e.mem_wstrb = s.data_wstrb;
        e.mem_wdata = s.data_wdata;
      end else begin
        e.mem_size = 2'd2;
        e.mem_addr = s.inst_addr;
      end
    end
    acc = asking  && s.mem_addr_ok;
    rsp = waiting && s.mem_data_ok;
    e.inst_addr_ok = acc && !m_own[k];
    e.data_addr_ok = acc &&  m_own[k];
    e.inst_data_ok = rsp && !m_own[k];
    e.data_data_ok = rsp &&  m_own[k];
    if (rsp && !m_own[k]) e.inst_rdata = s.mem_rdata;
    if (rsp &&  m_own[k]) e.data_rdata = s.mem_rdata;
    return e;
  endfunction

  task automatic model_step(input int k);
    if (!resetn) begin
      m_busy[k] = 1'b0; m_acc[k] = 1'b0; m_own[k] = 1'b0; m_last[k] = 1'b1;
    end else if (!m_busy[k]) begin
      if (s.inst_req || s.data_req) begin
        m_own[k]  = pick(k);
        m_busy[k] = 1'b1;
        m_acc[k]  = 1'b0;
      end
    end else if (!m_acc[k]) begin
      if (s.mem_addr_ok) begin
        m_acc[k]  = 1'b1;
        m_last[k] = m_own[k];
      end
    end else if (s.mem_data_ok) begin
      m_busy[k] = 1'b0;
    end
  endtask

  task automatic cmp(input int k, input obs_t a, input obs_t e);
    string p;
    p = $sformatf("dut%0d.", k);
    check({p, "inst_addr_ok"}, 32'(a.inst_addr_ok), 32'(e.inst_addr_ok));
    check({p, "inst_data_ok"}, 32'(a.inst_data_ok), 32'(e.inst_data_ok));
    check({p, "inst_rdata"},   a.inst_rdata,         e.inst_rdata);
    check({p, "data_addr_ok"}, 32'(a.data_addr_ok), 32'(e.data_addr_ok));
    check({p, "data_data_ok"}, 32'(a.data_data_ok), 32'(e.data_data_ok));
    check({p, "data_rdata"},   a.data_rdata,         e.data_rdata);
    check({p, "mem_req"},      32'(a.mem_req),      32'(e.mem_req));
    check({p, "mem_wr"},       32'(a.mem_wr),       32'(e.mem_wr));
    check({p, "mem_size"},     32'(a.mem_size),     32'(e.mem_size));
    check({p, "mem_addr"},     a.mem_addr,           e.mem_addr);
    check({p, "mem_wstrb"},    32'(a.mem_wstrb),    32'(e.mem_wstrb));
    check({p, "mem_wdata"},    a.mem_wdata,          e.mem_wdata);
  endtask

  // One clock: compare mid-cycle, then advance the model on the rising edge
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      snap[k] = ob[k];
      cmp(k, ob[k], model_out(k));
    end
    if (ob[0].inst_addr_ok) begin gq0.push_back(1'b0); gcyc0.push_back(cyc); end
    if (ob[0].data_addr_ok) begin gq0.push_back(1'b1); gcyc0.push_back(cyc); end
    if (ob[0].inst_data_ok || ob[0].data_data_ok) dcyc0.push_back(cyc);
    if (ob[1].inst_addr_ok) gq1.push_back(1'b0);
    if (ob[1].data_addr_ok) gq1.push_back(1'b1);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
    #1;
  endtask

  task automatic set_reset(input logic v);
    resetn = v;
    if (!v) model_reset();
  endtask

  initial begin
    int t0, n0, n1, n2, n3;
    s = '0;
    model_reset();
    set_reset(1'b0);

    // Reset: parked port, no pulses
    tick();
    tick();
    check("rst.mem_addr", snap[0].mem_addr, 32'h1c00_0000);
    check("rst.mem_req", 32'(snap[0].mem_req), 32'd0);
    check("rst.rr_mem_addr", snap[1].mem_addr, 32'h1c00_0000);
    set_reset(1'b1);
    tick();

    // Both requesters held high, zero-wait memory
    s.mem_addr_ok = 1'b1;
    s.mem_data_ok = 1'b1;
    s.mem_rdata   = 32'h1234_5678;
    s.inst_req    = 1'b1;
    s.inst_addr   = 32'h1c00_0040;
    s.data_req    = 1'b1;
    s.data_size   = SIZE_WORD;
    s.data_addr   = 32'h1c00_0200;
    gq0.delete(); gq1.delete(); gcyc0.delete(); dcyc0.delete();
    t0 = cyc;
    repeat (12) tick();
    check("fixed.grant_count", 32'(gq0.size()), 32'd4);
    check("rr.grant_count", 32'(gq1.size()), 32'd4);
    if (gq0.size() >= 3) begin
      check("fixed.grant0", 32'(gq0[0]), 32'd1);
      check("fixed.grant1", 32'(gq0[1]), 32'd1);
      check("fixed.grant2", 32'(gq0[2]), 32'd1);
    end
    if (gq1.size() >= 4) begin
      check("rr.grant0", 32'(gq1[0]), 32'd0);
      check("rr.grant1", 32'(gq1[1]), 32'd1);
      check("rr.grant2", 32'(gq1[2]), 32'd0);
      check("rr.grant3", 32'(gq1[3]), 32'd1);
    end
    if (gcyc0.size() >= 1) check("fixed.addr_ok_latency", 32'(gcyc0[0] - t0), 32'd1);
    if (dcyc0.size() >= 1) check("fixed.data_ok_latency", 32'(dcyc0[0] - t0), 32'd2);
    s.inst_req = 1'b0;
    s.data_req = 1'b0;
    repeat (4) tick();

    // Half-word write, single-cycle request
    s.data_req   = 1'b1;
    s.data_wr    = 1'b1;
    s.data_size  = SIZE_HALF;
    s.data_addr  = 32'h1c00_0100;
    s.data_wstrb = 4'b0011;
    s.data_wdata = 32'hcafe_1234;
    n0 = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) s.data_req = 1'b0;
      if (snap[0].mem_wr) n0++;
      if (snap[0].mem_wstrb == 4'b0011) n1++;
      if (snap[0].data_data_ok) n2++;
    end
    check("wr.mem_wr_cycles", 32'(n0), 32'd1);
    check("wr.wstrb_cycles", 32'(n1), 32'd1);
    check("wr.data_ok_pulses", 32'(n2), 32'd1);
    s.data_wr    = 1'b0;
    s.data_wstrb = 4'b0000;
    s.data_wdata = 32'h0;

    // Slow accept with a spurious response strobe while requesting; request dropped early
    s.mem_addr_ok = 1'b0;
    s.mem_data_ok = 1'b1;
    s.mem_rdata   = 32'h0bad_f00d;
    s.inst_req    = 1'b1;
    s.inst_addr   = 32'h1c00_0040;
    n0 = 0; n1 = 0; n2 = 0; n3 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) s.inst_req = 1'b0;
      if (i == 2) s.mem_addr_ok = 1'b1;
      if (snap[0].mem_req) n0++;
      if (snap[0].mem_req && snap[0].mem_addr == 32'h1c00_0040) n1++;
      if (snap[0].mem_req && (snap[0].inst_data_ok || snap[0].data_data_ok)) n2++;
      if (snap[0].inst_data_ok) n3++;
    end
    check("slow.mem_req_cycles", 32'(n0), 32'd3);
    check("slow.stable_addr_cycles", 32'(n1), 32'd3);
    check("slow.spurious_data_ok", 32'(n2), 32'd0);
    check("slow.inst_data_ok_pulses", 32'(n3), 32'd1);

    // Reset while waiting for a read response
    s.mem_addr_ok = 1'b1;
    s.mem_data_ok = 1'b0;
    s.data_req    = 1'b1;
    s.data_size   = SIZE_WORD;
    s.data_addr   = 32'h1c00_0300;
    tick();
    s.data_req = 1'b0;
    tick();
    tick();
    check("midrst.resp_mem_req", 32'(snap[0].mem_req), 32'd0);
    set_reset(1'b0);
    tick();
    check("midrst.in_reset_addr", snap[0].mem_addr, 32'h1c00_0000);
    check("midrst.in_reset_data_ok", 32'(snap[0].data_data_ok), 32'd0);
    set_reset(1'b1);
    s.mem_data_ok = 1'b1;
    s.mem_rdata   = 32'hdead_beef;
    n0 = 0;
    repeat (3) begin
      tick();
      n0 += int'(snap[0].inst_data_ok) + int'(snap[0].data_data_ok)
          + int'(snap[1].inst_data_ok) + int'(snap[1].data_data_ok);
    end
    check("midrst.late_data_ok", 32'(n0), 32'd0);
    s.data_req = 1'b1;
    tick();
    s.data_req = 1'b0;
    tick();
    check("midrst.fresh_addr_ok", 32'(snap[0].data_addr_ok), 32'd1);
    tick();
    check("midrst.fresh_data_ok", 32'(snap[0].data_data_ok), 32'd1);
    check("midrst.fresh_rdata", snap[0].data_rdata, 32'hdead_beef);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: RR, default 0; 0 = fixed data-over-inst priority, 1 = round-robin between requesters.
REQ-002 Parameter: ENTRYPOINT, default 32'h1c000000; value of mem_addr when the port is idle.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 inst_req / inst_addr  input  1 / 32  instruction read request and word address.
REQ-006 inst_addr_ok / inst_data_ok  output  1 / 1  request accepted / read data valid, one-cycle pulses.
REQ-007 inst_rdata  output  32  instruction read data, valid only with inst_data_ok.
REQ-008 data_req / data_wr / data_size  input  1 / 1 / 2  data request, write flag, size (0 = byte, 1 = half, 2 = word).
REQ-009 data_addr / data_wstrb / data_wdata  input  32 / 4 / 32  data address, byte strobe and write data.
REQ-010 data_addr_ok / data_data_ok / data_rdata  output  1 / 1 / 32  same meaning as the inst_* outputs.
REQ-011 mem_req / mem_wr / mem_size / mem_addr / mem_wstrb / mem_wdata  output  1 / 1 / 2 / 32 / 4 / 32  shared memory port request.
REQ-012 mem_addr_ok / mem_data_ok / mem_rdata  input  1 / 1 / 32  shared port accept, response valid and read data.

Function
REQ-013 The FSM SHALL have three states: IDLE, REQ and RESP, plus a 1-bit owner register (0 = inst, 1 = data) and a 1-bit last_grant register.
REQ-014 IDLE: mem_req = 0; if any request is pending, latch the winner into owner and go to REQ next cycle; otherwise stay in IDLE.
REQ-015 Winner selection when RR = 0: data wins whenever data_req = 1.
REQ-016 Winner selection when RR = 1: on a simultaneous request the requester that is not last_grant wins; a single request always wins.
REQ-017 REQ: mem_req = 1; mem_* request fields come from the owner's inputs; inst requests drive mem_wr = 0, mem_size = 2 and mem_wstrb = 0.
REQ-018 REQ: when mem_addr_ok = 1, pulse the owner's *_addr_ok in the same cycle (combinational pass-through), set last_grant = owner and go to RESP.
REQ-019 REQ: the owner is frozen; the other requester gets no addr_ok even if its request is pending.
REQ-020 RESP: mem_req = 0; when mem_data_ok = 1, pulse the owner's *_data_ok in the same cycle, route mem_rdata to the owner's *_rdata and return to IDLE.
REQ-021 Write responses also pass through data_data_ok.
REQ-022 Only one transaction SHALL be outstanding at a time.
REQ-023 Latency: at least 3 cycles from request to next grant (IDLE, REQ, RESP); with zero-wait memory, addr_ok is seen 1 cycle after the request and data_ok 2 cycles after it.
REQ-024 mem_addr_ok outside REQ and mem_data_ok outside RESP SHALL be ignored, producing no pulse.
REQ-025 A requester that drops its request while in REQ without receiving addr_ok SHALL still be served; its request fields are held by the requester (protocol rule).
REQ-026 A non-owner *_rdata output SHALL be 0, and *_data_ok SHALL never be asserted to both requesters in one cycle.
REQ-027 When not in REQ, mem_addr = ENTRYPOINT and all other mem_* request fields are 0.

Reset
REQ-028 On resetn = 0 (asynchronous): state = IDLE, owner = 0, last_grant = 1 (so inst wins the first tie in RR mode).
REQ-029 During reset all outputs SHALL be 0, except mem_addr = ENTRYPOINT.
REQ-030 Reset mid-transaction SHALL drop the pending response; a later mem_data_ok in IDLE is ignored.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2), the size codes and ENTRYPOINT.
REQ-032 One sub-module, arb_pick, SHALL hold the combinational winner selection, taking RR, last_grant and both req bits.

Verification
REQ-033 RR = 0, inst_req and data_req held high, zero-wait memory -> grant order data, data, data; inst starves; data_addr_ok at cycle 1 and data_data_ok at cycle 2.
REQ-034 RR = 1, both requests held high -> grant order inst, data, inst, data; last_grant toggles each transaction.
REQ-035 Data write addr 0x1c000100, wstrb 4'b0011, size 1 -> mem_wr = 1 and mem_wstrb = 4'b0011 for exactly the REQ cycles; data_data_ok pulses once.
REQ-036 mem_addr_ok delayed 3 cycles in REQ -> mem_req held 3 cycles with stable mem_addr; a spurious mem_data_ok during REQ produces no *_data_ok.
REQ-037 resetn asserted in RESP, then mem_data_ok with rdata 0xdeadbeef after release -> no data_ok to either requester; state = IDLE.
